// File: rtl/speed_actuator_pkg.sv
// Shared types and helpers for the speed actuation stage and the control FSM.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: door-state encoding, speed width, saturating speed arithmetic.
package speed_actuator_pkg;

  localparam int SPEED_W = 8;

  typedef enum logic [1:0] {
    LOCKED = 2'b00,
    ARMING = 2'b01,
    OPEN   = 2'b10
  } door_state_t;

  // Add a step and clamp at the ceiling. The 9-bit sum keeps a carry out of
  // 255 from wrapping back to a small speed.
  function automatic logic [SPEED_W-1:0] speed_up(
    input logic [SPEED_W-1:0] spd,
    input logic [SPEED_W:0]   step,
    input logic [SPEED_W:0]   ceil
  );
    logic [SPEED_W:0] sum;
    sum = {1'b0, spd} + step;
    return (sum > ceil) ? ceil[SPEED_W-1:0] : sum[SPEED_W-1:0];
  endfunction

  // Subtract a step and floor at zero.
  function automatic logic [SPEED_W-1:0] speed_down(
    input logic [SPEED_W-1:0] spd,
    input logic [SPEED_W:0]   step
  );
    logic [SPEED_W:0] diff;
    diff = {1'b0, spd} - step;
    return ({1'b0, spd} > step) ? diff[SPEED_W-1:0] : '0;
  endfunction

endpackage

// File: rtl/speed_actuator_tick_gen.sv
// Prescaler producing the speed update strobe once every TICK_DIV cycles.
// Latency: speed_tick is high in the cycle the count sits at TICK_DIV-1.
// Backpressure: none, free-running.
// Ports: clk, rst (async active-low), speed_tick (out, 1-cycle pulse).
module speed_actuator_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic speed_tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign speed_tick = (cnt == LAST);

endmodule

// File: rtl/speed_actuator.sv
// Vehicle model: rate-limited speed, throttle/brake strobes, door-release FSM.
// Latency: speed/strobes update on the tick edge, door FSM every edge; all registered.
// Backpressure: none; commands are levels sampled every cycle.
// Ports: clk, rst (async active-low), accelerate_car, unlock_door in;
//        car_speed[7:0], speed_tick, throttle, brake, door_open out.
module speed_actuator
  import speed_actuator_pkg::*;
#(
  parameter int TICK_DIV    = 4,
  parameter int ACC_STEP    = 2,
  parameter int DEC_STEP    = 4,
  parameter int MAX_SPEED   = 200,
  parameter int UNLOCK_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               accelerate_car,
  input  logic               unlock_door,
  output logic [SPEED_W-1:0] car_speed,
  output logic               speed_tick,
  output logic               throttle,
  output logic               brake,
  output logic               door_open
);

  localparam logic [SPEED_W:0] ACC9 = ACC_STEP[SPEED_W:0];
  localparam logic [SPEED_W:0] DEC9 = DEC_STEP[SPEED_W:0];
  localparam logic [SPEED_W:0] MAX9 = MAX_SPEED[SPEED_W:0];

  localparam int HC_W = $clog2(UNLOCK_HOLD + 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(UNLOCK_HOLD);

  door_state_t     door_state;
  logic [HC_W-1:0] hold_cnt;
  logic            acc_ok;
  logic            qual;

  speed_actuator_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk        (clk),
    .rst        (rst),
    .speed_tick (speed_tick)
  );

  // Interlock: the door must be fully LOCKED for acceleration to apply.
  assign acc_ok = accelerate_car && (door_state == LOCKED);
  // Accelerate wins over unlock, and the door only arms at standstill.
  assign qual   = unlock_door && !accelerate_car && (car_speed == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      car_speed <= '0;
      throttle  <= 1'b0;
      brake     <= 1'b0;
    end else if (speed_tick) begin
      car_speed <= acc_ok ? speed_up(car_speed, ACC9, MAX9)
                          : speed_down(car_speed, DEC9);
      throttle  <= acc_ok;
      brake     <= !acc_ok && (car_speed != '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      door_state <= LOCKED;
      hold_cnt   <= '0;
      door_open  <= 1'b0;
    end else begin
      case (door_state)
        LOCKED: begin
          if (qual) begin
            // The qualifying cycle that leaves LOCKED is the first counted one.
            if (UNLOCK_HOLD <= 1) begin
              door_state <= OPEN;
              door_open  <= 1'b1;
              hold_cnt   <= '0;
            end else begin
              door_state <= ARMING;
              hold_cnt   <= HC_W'(1);
            end
          end
        end
        ARMING: begin
          if (!qual) begin
            door_state <= LOCKED;
            hold_cnt   <= '0;
          end else if (hold_cnt + 1'b1 == HOLD_LAST) begin
            door_state <= OPEN;
            door_open  <= 1'b1;
            hold_cnt   <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        OPEN: begin
          if (!unlock_door || accelerate_car) begin
            door_state <= LOCKED;
            door_open  <= 1'b0;
          end
        end
        default: begin
          door_state <= LOCKED;
          door_open  <= 1'b0;
          hold_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_speed_actuator.sv
// Bench for speed_actuator: two instances (default ceiling 200 and ceiling 255)
// share stimulus; a behavioural model is compared every cycle, and directed
// scenarios pin reset, ramp, saturation, decel floor, door hold and interlock.
module tb_speed_actuator;

  localparam int TD   = 4;
  localparam int ACC  = 2;
  localparam int DEC  = 4;
  localparam int HOLD = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       acc = 1'b0;
  logic       unl = 1'b0;
  logic [7:0] spd0, spd1;
  logic       tick0, tick1, thr0, thr1, brk0, brk1, door0, door1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  speed_actuator dut0 (
    .clk(clk), .rst(rst), .accelerate_car(acc), .unlock_door(unl),
    .car_speed(spd0), .speed_tick(tick0), .throttle(thr0), .brake(brk0),
    .door_open(door0)
  );

  speed_actuator #(.MAX_SPEED(255)) dut1 (
    .clk(clk), .rst(rst), .accelerate_car(acc), .unlock_door(unl),
    .car_speed(spd1), .speed_tick(tick1), .throttle(thr1), .brake(brk1),
    .door_open(door1)
  );

  // ---------------- behavioural model ----------------
  // m_cyc counts edges since reset release; m_run counts consecutive
  // qualified cycles while the door is not yet released.
  int m_cyc;
  int m_spd  [2];
  bit m_thr  [2];
  bit m_brk  [2];
  bit m_open [2];
  int m_run  [2];

  function automatic int max_of(input int i);
    return (i == 0) ? 200 : 255;
  endfunction

  function automatic bit m_tick();
    return (m_cyc % TD) == (TD - 1);
  endfunction

  function automatic bit m_locked(input int i);
    return (m_run[i] == 0) && !m_open[i];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cyc <= 0;
      for (int i = 0; i < 2; i++) begin
        m_spd[i]  <= 0;
        m_thr[i]  <= 1'b0;
        m_brk[i]  <= 1'b0;
        m_open[i] <= 1'b0;
        m_run[i]  <= 0;
      end
    end else begin
      m_cyc <= m_cyc + 1;
      for (int i = 0; i < 2; i++) begin
        if (m_tick()) begin
          if (acc && m_locked(i)) begin
            m_spd[i] <= (m_spd[i] + ACC > max_of(i)) ? max_of(i) : m_spd[i] + ACC;
            m_thr[i] <= 1'b1;
            m_brk[i] <= 1'b0;
          end else begin
            m_spd[i] <= (m_spd[i] > DEC) ? m_spd[i] - DEC : 0;
            m_thr[i] <= 1'b0;
            m_brk[i] <= (m_spd[i] != 0);
          end
        end
        if (m_open[i]) begin
          m_open[i] <= unl && !acc;
        end else if (unl && !acc && m_spd[i] == 0) begin
          if (m_run[i] + 1 >= HOLD) begin
            m_open[i] <= 1'b1;
            m_run[i]  <= 0;
          end else begin
            m_run[i] <= m_run[i] + 1;
          end
        end else begin
          m_run[i] <= 0;
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    for (int i = 0; i < 2; i++) begin
      logic [11:0] act_v, exp_v;
      act_v = (i == 0) ? {spd0, tick0, thr0, brk0, door0}
                       : {spd1, tick1, thr1, brk1, door1};
      exp_v = {8'(m_spd[i]), m_tick(), m_thr[i], m_brk[i], m_open[i]};
      n_checks++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL model_dut%0d t=%0t got spd=%0d tick=%b thr=%b brk=%b door=%b, expected spd=%0d tick=%b thr=%b brk=%b door=%b",
                 i, $time, act_v[11:4], act_v[3], act_v[2], act_v[1], act_v[0],
                 exp_v[11:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // Wait until the tick is active, then cross the update edge.
  task automatic wait_tick_edge();
    int g = 0;
    while (!tick0 && g < 2 * TD) begin
      edge1();
      g++;
    end
    chk("tick_seen", int'(tick0), 1);
    edge1();
  endtask

  task automatic ticks(input int n);
    repeat (n) wait_tick_edge();
  endtask

  // Release reset and measure cycles until the first tick.
  task automatic release_rst();
    int n = 0;
    rst = 1'b1;
    do begin
      edge1();
      n++;
    end while (!tick0 && n < 10);
    chk("first_tick_latency", n, TD - 1);
  endtask

  task automatic zero_outputs(input string tag);
    chk({tag, "_speed"}, int'(spd0), 0);
    chk({tag, "_tick"},  int'(tick0), 0);
    chk({tag, "_thr"},   int'(thr0), 0);
    chk({tag, "_brk"},   int'(brk0), 0);
    chk({tag, "_door"},  int'(door0), 0);
  endtask

  task automatic stimulus();
    // Reset state
    repeat (3) edge1();
    zero_outputs("reset");
    acc = 1'b1;
    release_rst();

    // Ramp 2..20, one change per TD clocks
    for (int k = 1; k <= 10; k++) begin
      edge1();
      chk("ramp_speed", int'(spd0), 2 * k);
      chk("ramp_thr", int'(thr0), 1);
      chk("ramp_brk", int'(brk0), 0);
      repeat (TD - 1) edge1();
      chk("ramp_hold", int'(spd0), 2 * k);
    end
    ticks(15);
    chk("speed50", int'(spd0), 50);

    // Asynchronous reset mid-tick
    edge1();
    rst = 1'b0;
    #1;
    zero_outputs("async_rst");
    repeat (2) edge1();
    zero_outputs("rst_held");
    release_rst();

    // Saturation at 200 and at 255
    ticks(99);
    chk("sat_198", int'(spd0), 198);
    ticks(1);
    chk("sat_200", int'(spd0), 200);
    ticks(1);
    chk("sat_stay", int'(spd0), 200);
    ticks(26);
    chk("wide_254", int'(spd1), 254);
    ticks(1);
    chk("wide_255", int'(spd1), 255);
    ticks(1);
    chk("wide_stay", int'(spd1), 255);
    chk("sat_still", int'(spd0), 200);

    // Decel floor from 6
    rst = 1'b0;
    edge1();
    release_rst();
    ticks(3);
    chk("dec_start", int'(spd0), 6);
    acc = 1'b0;
    ticks(1);
    chk("dec_2", int'(spd0), 2);
    chk("dec_brk1", int'(brk0), 1);
    chk("dec_thr", int'(thr0), 0);
    ticks(1);
    chk("dec_0", int'(spd0), 0);
    chk("dec_brk2", int'(brk0), 1);
    ticks(1);
    chk("dec_floor", int'(spd0), 0);
    chk("dec_brk3", int'(brk0), 0);

    // Door hold with an interrupted attempt
    unl = 1'b1;
    repeat (5) edge1();
    unl = 1'b0;
    edge1();
    chk("door_abort", int'(door0), 0);
    unl = 1'b1;
    repeat (7) edge1();
    chk("door_7", int'(door0), 0);
    edge1();
    chk("door_8", int'(door0), 1);
    repeat (3) edge1();
    chk("door_held", int'(door0), 1);

    // Interlock
    acc = 1'b1;
    edge1();
    chk("intl_door", int'(door0), 0);
    chk("intl_speed", int'(spd0), 0);
    wait_tick_edge();
    chk("intl_resume", int'(spd0), 2);
    chk("intl_thr", int'(thr0), 1);

    // Randomized traffic, checked by the model every cycle
    begin
      int mode = 0;
      for (int c = 0; c < 3000; c++) begin
        if (c % 32 == 0) mode = $urandom_range(0, 3);
        case (mode)
          0: begin acc = ($urandom_range(0, 9) < 8); unl = ($urandom_range(0, 9) == 0); end
          1: begin acc = ($urandom_range(0, 19) == 0); unl = ($urandom_range(0, 19) != 0); end
          2: begin acc = $urandom_range(0, 1); unl = $urandom_range(0, 1); end
          default: begin acc = 1'b0; unl = ($urandom_range(0, 9) != 0); end
        endcase
        if ($urandom_range(0, 699) == 0) begin
          rst = 1'b0;
          edge1();
          rst = 1'b1;
        end
        edge1();
      end
    end
    repeat (4) edge1();
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        compare_cycle();
      end
      stimulus();
      begin
        #1000000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
      end
    join_any
    disable fork;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
